// File: rtl/jackpot_round_ctrl.sv
// ==== jackpot_round_ctrl : LED-chase jackpot round controller ====
// ==== rev 1.0 : prescaled chase, press judging, win hold, score/level tracking ====
`default_nettype none

module jackpot_round_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int WIN_HOLD  = 4,
  parameter int MAX_LEVEL = 3,
  parameter int CNT_W     = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [3:0] switches_i,
  output logic [3:0] leds_o,
  output logic       win_o,
  output logic [1:0] level_o,
  output logic [7:0] score_o,
  output logic       busy_o
);

  localparam int                HOLD_W     = (WIN_HOLD > 1) ? $clog2(WIN_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(WIN_HOLD - 1);
  localparam logic [1:0]        LEVEL_MAX  = 2'(MAX_LEVEL);
  localparam logic [CNT_W-1:0]  TICK_BASE  = CNT_W'(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WIN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        leds_q, leds_d;
  logic              win_q, win_d;
  logic [1:0]        level_q, level_d;
  logic [7:0]        score_q, score_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [3:0]        sync1_q, sync2_q, prev_q;

  logic [CNT_W-1:0]  period;
  logic              tick;
  logic [3:0]        press;

  // Step period halves with every level; tick marks the last count of a step.
  assign period = TICK_BASE >> level_q;
  assign tick   = (cnt_q >= (period - CNT_W'(1)));
  assign press  = sync2_q & ~prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      leds_q  <= 4'b0000;
      win_q   <= 1'b0;
      level_q <= 2'd0;
      score_q <= 8'd0;
      cnt_q   <= '0;
      hold_q  <= '0;
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
      prev_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      win_q   <= win_d;
      level_q <= level_d;
      score_q <= score_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sync1_q <= switches_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    win_d   = 1'b0;
    level_d = level_q;
    score_d = score_q;
    hold_d  = hold_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        leds_d = 4'b0000;
        cnt_d  = '0;
        hold_d = '0;
        if (start_i && !stop_i) begin
          state_d = S_RUN;
          leds_d  = 4'b0001;
        end
      end

      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          leds_d  = 4'b0000;
          cnt_d   = '0;
        end else if ((press != 4'b0000) && (press == leds_q)) begin
          // A win discards any rotation due in the same cycle.
          state_d = S_WIN;
          win_d   = 1'b1;
          leds_d  = 4'b1111;
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          level_d = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 2'd1;
          cnt_d   = '0;
          hold_d  = '0;
        end else begin
          if (press != 4'b0000) begin
            level_d = 2'd0;
          end
          if (tick) begin
            leds_d = {leds_q[2:0], leds_q[3]};
          end
        end
      end

      S_WIN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          leds_d  = 4'b0000;
          cnt_d   = '0;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_RUN;
            leds_d  = 4'b0001;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        leds_d  = 4'b0000;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign leds_o  = leds_q;
  assign win_o   = win_q;
  assign level_o = level_q;
  assign score_o = score_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_jackpot_round_ctrl.sv
// ==== tb_jackpot_round_ctrl : scoreboard bench for the jackpot round controller ====
// ==== rev 1.0 : TICK_DIV=8, WIN_HOLD=2, MAX_LEVEL=2 ====
`default_nettype none

module tb_jackpot_round_ctrl;

  logic       clk;
  logic       rst;
  logic       start_i;
  logic       stop_i;
  logic [3:0] switches_i;
  logic [3:0] leds_o;
  logic       win_o;
  logic [1:0] level_o;
  logic [7:0] score_o;
  logic       busy_o;

  typedef struct {
    logic [7:0] score;
    logic [1:0] level;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jackpot_round_ctrl #(
    .TICK_DIV (8),
    .WIN_HOLD (2),
    .MAX_LEVEL(2),
    .CNT_W    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .switches_i(switches_i),
    .leds_o    (leds_o),
    .win_o     (win_o),
    .level_o   (level_o),
    .score_o   (score_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for the win pulse, then pops the scoreboard and checks it.
  task automatic expect_win(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    while (!win_o && lat < 10) begin
      step(1);
      lat++;
    end
    checks++;
    if (!win_o) begin
      errors++;
      $display("FAIL %s timeout: win got 0 want 1", name);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      if (lat !== 3 || leds_o !== 4'b1111 || score_o !== e.score || level_o !== e.level) begin
        errors++;
        $display("FAIL %s: lat %0d leds %b score %0d level %0d want lat 3 leds 1111 score %0d level %0d",
                 name, lat, leds_o, score_o, level_o, e.score, e.level);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; stop_i = 1'b0; switches_i = 4'b0000;
    step(2);
    checks++;
    if ({leds_o, win_o, level_o, score_o, busy_o} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got leds %b win %b lvl %0d score %0d busy %b want all 0",
               leds_o, win_o, level_o, score_o, busy_o);
    end
    rst = 1'b1;
    step(4);
    checks++;
    if (busy_o !== 1'b0 || leds_o !== 4'b0000) begin
      errors++;
      $display("FAIL idle_hold: got busy %b leds %b want 0 0000", busy_o, leds_o);
    end
    switches_i = 4'b0001;
    step(6);
    checks++;
    if (score_o !== 8'd0 || win_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_press: got score %0d win %b busy %b want 0 0 0", score_o, win_o, busy_o);
    end
    switches_i = 4'b0000;
    step(4);
  endtask

  task automatic test_rotation();
    logic [3:0] seq [3];
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    checks++;
    if (leds_o !== 4'b0001 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: got leds %b busy %b want 0001 1", leds_o, busy_o);
    end
    step(7);
    checks++;
    if (leds_o !== 4'b0001) begin
      errors++;
      $display("FAIL pre_tick: got leds %b want 0001", leds_o);
    end
    step(1);
    checks++;
    if (leds_o !== 4'b0010) begin
      errors++;
      $display("FAIL step_8: got leds %b want 0010", leds_o);
    end
    for (int k = 0; k < 3; k++) begin
      step(8);
      checks++;
      if (leds_o !== seq[k]) begin
        errors++;
        $display("FAIL rotate_%0d: got leds %b want %b", k, leds_o, seq[k]);
      end
    end
  endtask

  task automatic test_win();
    step(16);
    checks++;
    if (leds_o !== 4'b0100) begin
      errors++;
      $display("FAIL win_setup: got leds %b want 0100", leds_o);
    end
    sb.push_back('{score: 8'd1, level: 2'd1});
    switches_i = 4'b0100;
    expect_win("win_first");
    switches_i = 4'b0000;
    step(1);
    checks++;
    if (win_o !== 1'b0 || leds_o !== 4'b1111) begin
      errors++;
      $display("FAIL win_pulse: got win %b leds %b want 0 1111", win_o, leds_o);
    end
    step(6);
    checks++;
    if (leds_o !== 4'b1111) begin
      errors++;
      $display("FAIL hold_end: got leds %b want 1111", leds_o);
    end
    step(1);
    checks++;
    if (leds_o !== 4'b0001 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_exit: got leds %b busy %b want 0001 1", leds_o, busy_o);
    end
    step(4);
    checks++;
    if (leds_o !== 4'b0010) begin
      errors++;
      $display("FAIL level1_period: got leds %b want 0010", leds_o);
    end
  endtask

  task automatic test_miss();
    step(12);
    checks++;
    if (leds_o !== 4'b0001 || level_o !== 2'd1) begin
      errors++;
      $display("FAIL miss_setup: got leds %b level %0d want 0001 1", leds_o, level_o);
    end
    switches_i = 4'b1000;
    step(3);
    checks++;
    if (level_o !== 2'd0 || score_o !== 8'd1 || win_o !== 1'b0 || leds_o !== 4'b0001) begin
      errors++;
      $display("FAIL miss: got level %0d score %0d win %b leds %b want 0 1 0 0001",
               level_o, score_o, win_o, leds_o);
    end
    switches_i = 4'b0000;
    step(4);
    checks++;
    if (leds_o !== 4'b0001) begin
      errors++;
      $display("FAIL miss_no_reset: got leds %b want 0001", leds_o);
    end
    step(1);
    checks++;
    if (leds_o !== 4'b0010) begin
      errors++;
      $display("FAIL miss_continue: got leds %b want 0010", leds_o);
    end
    step(8);
    checks++;
    if (leds_o !== 4'b0100) begin
      errors++;
      $display("FAIL miss_period8: got leds %b want 0100", leds_o);
    end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{score: 8'd2, level: 2'd1});
    switches_i = 4'b0100;
    expect_win("win_b2b_1");
    switches_i = 4'b0010;
    step(7);
    checks++;
    if (score_o !== 8'd2 || leds_o !== 4'b1111) begin
      errors++;
      $display("FAIL win_ignores_press: got score %0d leds %b want 2 1111", score_o, leds_o);
    end
    step(1);
    sb.push_back('{score: 8'd3, level: 2'd2});
    switches_i = 4'b0011;
    expect_win("win_b2b_2");
    switches_i = 4'b0000;
    step(4);
    checks++;
    if (leds_o !== 4'b0001) begin
      errors++;
      $display("FAIL level2_hold: got leds %b want 0001", leds_o);
    end
    step(2);
    checks++;
    if (leds_o !== 4'b0010) begin
      errors++;
      $display("FAIL level2_period: got leds %b want 0010", leds_o);
    end
    step(1);
    // Judged on the cycle whose tick would move 0100 to 1000.
    sb.push_back('{score: 8'd4, level: 2'd2});
    switches_i = 4'b0100;
    expect_win("win_on_tick");
    switches_i = 4'b0000;
  endtask

  task automatic test_reset_and_stop();
    step(1);
    checks++;
    if (busy_o !== 1'b1 || leds_o !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset_win: got busy %b leds %b want 1 1111", busy_o, leds_o);
    end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    checks++;
    if ({leds_o, win_o, level_o, score_o, busy_o} !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: got leds %b win %b lvl %0d score %0d busy %b want all 0",
               leds_o, win_o, level_o, score_o, busy_o);
    end
    step(2);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy %b want 0", busy_o);
    end
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(16);
    sb.push_back('{score: 8'd1, level: 2'd1});
    switches_i = 4'b0100;
    expect_win("win_after_reset");
    switches_i = 4'b0000;
    step(8);
    checks++;
    if (leds_o !== 4'b0001 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL rerun: got leds %b busy %b want 0001 1", leds_o, busy_o);
    end
    step(2);
    stop_i = 1'b1;
    step(1);
    checks++;
    if (leds_o !== 4'b0000 || busy_o !== 1'b0 || score_o !== 8'd1 || level_o !== 2'd1) begin
      errors++;
      $display("FAIL stop: got leds %b busy %b score %0d level %0d want 0000 0 1 1",
               leds_o, busy_o, score_o, level_o);
    end
    start_i = 1'b1;
    step(1);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stop_priority: got busy %b want 0", busy_o);
    end
    stop_i = 1'b0;
    step(1);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || leds_o !== 4'b0001 || level_o !== 2'd1) begin
      errors++;
      $display("FAIL restart: got busy %b leds %b level %0d want 1 0001 1", busy_o, leds_o, level_o);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_win();
    test_miss();
    test_back_to_back();
    test_reset_and_stop();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
